// File: rtl/cm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cm_pkg
// Brief    : Shared defaults, address typedef and clog2 helper for the
//            candidate-match buffer slice.
// Revision : 1.0
// ============================================================================
package cm_pkg;

    localparam int CM_DATA_W = 12;
    localparam int CM_ADDR_W = 5;
    localparam int CM_PAGE_W = 1;
    localparam int CM_TMUX   = 6;

    typedef struct packed {
        logic [CM_PAGE_W-1:0] page;
        logic [CM_ADDR_W-1:0] entry;
    } cm_addr_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/candidate_match_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : candidate_match_buf_if
// Brief    : Candidate input streams and random-access read port.
// Revision : 1.0
// ============================================================================
interface candidate_match_buf_if
    import cm_pkg::*;
#(
    parameter int DATA_W = CM_DATA_W,
    parameter int ADDR_W = CM_ADDR_W,
    parameter int PAGE_W = CM_PAGE_W,
    parameter int NIN    = 2
);
    logic [NIN*DATA_W-1:0]    din;
    logic [NIN-1:0]           din_valid;
    logic [NIN-1:0]           din_ready;
    logic [PAGE_W+ADDR_W-1:0] read_add;
    logic                     read_en;
    logic [DATA_W-1:0]        data_out;
    logic                     data_out_valid;

    modport master (
        output din, din_valid, read_add, read_en,
        input  din_ready, data_out, data_out_valid
    );

    modport slave (
        input  din, din_valid, read_add, read_en,
        output din_ready, data_out, data_out_valid
    );
endinterface
`default_nettype wire

// File: rtl/pipe_delay.sv
`default_nettype none
// ============================================================================
// Module   : pipe_delay
// Brief    : Single-bit delay line of DELAY clocks with async clear.
// Revision : 1.0
// ============================================================================
module pipe_delay #(
    parameter int DELAY = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [DELAY-1:0] pipe_q;

    generate
        if (DELAY == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pipe_q <= '0;
                else        pipe_q <= d_i;
            end
        end else begin : g_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pipe_q <= '0;
                else        pipe_q <= {pipe_q[DELAY-2:0], d_i};
            end
        end
    endgenerate

    assign q_o = pipe_q[DELAY-1];
endmodule
`default_nettype wire

// File: rtl/reg_array.sv
`default_nettype none
// ============================================================================
// Module   : reg_array
// Brief    : Simple dual-port register array with registered read.
// Revision : 1.0
// ============================================================================
module reg_array #(
    parameter int DEPTH_W = 6,
    parameter int WIDTH   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we_i,
    input  logic [DEPTH_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]   wdata_i,
    input  logic               re_i,
    input  logic [DEPTH_W-1:0] raddr_i,
    output logic [WIDTH-1:0]   rdata_o,
    output logic               rvalid_o
);
    logic [WIDTH-1:0] mem_q [0:(1<<DEPTH_W)-1];
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= re_i;
            if (re_i) rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter, one-hot grant searching upward from pointer.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NIN   = 2,
    parameter int PTR_W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NIN-1:0] req_i,
    output logic [NIN-1:0] grant_o,
    output logic           any_o
);
    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Offset o from the pointer maps to channel c, wrapping once past NIN-1.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        ptr_d   = ptr_q;
        for (int o = 0; o < NIN; o++) begin
            for (int c = 0; c < NIN; c++) begin
                if (!any_o && req_i[c] &&
                    ((int'(ptr_q) + o == c) || (int'(ptr_q) + o == c + NIN))) begin
                    grant_o[c] = 1'b1;
                    any_o      = 1'b1;
                    ptr_d      = (c == NIN - 1) ? '0 : PTR_W'(c + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule
`default_nettype wire

// File: rtl/candidate_match_buf.sv
`default_nettype none
// ============================================================================
// Module   : candidate_match_buf
// Brief    : Multi-channel, page-rotated candidate-match buffer with per-page
//            count/overflow reporting and random-access read of closed pages.
// Revision : 1.0
// ============================================================================
module candidate_match_buf
    import cm_pkg::*;
#(
    parameter int DATA_W = CM_DATA_W,
    parameter int ADDR_W = CM_ADDR_W,
    parameter int PAGE_W = CM_PAGE_W,
    parameter int NIN    = 2,
    parameter int TMUX   = CM_TMUX
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 done,
    candidate_match_buf_if.slave bus,
    output logic [ADDR_W:0]      number_out,
    output logic                 number_valid,
    output logic                 overflow
);
    localparam int PTR_W  = (NIN > 1) ? clog2(NIN) : 1;
    localparam int MEM_AW = PAGE_W + ADDR_W;

    logic [NIN-1:0]    grant;
    logic              any_grant;
    logic              hs;
    logic              full;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [MEM_AW-1:0] waddr;

    logic [PAGE_W-1:0] wr_page_q, wr_page_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W:0]   number_q, number_d;
    logic              ovf_q, ovf_d;
    logic              overflow_q, overflow_d;
    logic              nvalid_q;

    rr_arbiter #(
        .NIN   (NIN),
        .PTR_W (PTR_W)
    ) u_arb (
        .clk     (clk),
        .rst_n   (reset),
        .req_i   (bus.din_valid),
        .grant_o (grant),
        .any_o   (any_grant)
    );

    // Grants are suppressed while reset is held so nothing handshakes.
    assign bus.din_ready = grant & {NIN{reset}};
    assign hs            = any_grant & reset;
    assign full          = wr_cnt_q[ADDR_W];

    always_comb begin
        wdata = '0;
        for (int c = 0; c < NIN; c++) begin
            if (grant[c]) wdata = bus.din[c*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        wr_page_d  = wr_page_q;
        wr_cnt_d   = wr_cnt_q;
        ovf_d      = ovf_q;
        number_d   = number_q;
        overflow_d = overflow_q;
        we         = 1'b0;
        waddr      = {wr_page_q, wr_cnt_q[ADDR_W-1:0]};
        if (start) begin
            number_d   = wr_cnt_q;
            overflow_d = ovf_q;
            wr_page_d  = wr_page_q + 1'b1;
            ovf_d      = 1'b0;
            wr_cnt_d   = {{ADDR_W{1'b0}}, hs};
            // A word arriving with start lands in entry 0 of the new page.
            we         = hs;
            waddr      = {wr_page_d, {ADDR_W{1'b0}}};
        end else if (hs) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                we       = 1'b1;
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_page_q  <= '1;
            wr_cnt_q   <= '0;
            ovf_q      <= 1'b0;
            number_q   <= '0;
            overflow_q <= 1'b0;
            nvalid_q   <= 1'b0;
        end else begin
            wr_page_q  <= wr_page_d;
            wr_cnt_q   <= wr_cnt_d;
            ovf_q      <= ovf_d;
            number_q   <= number_d;
            overflow_q <= overflow_d;
            nvalid_q   <= start;
        end
    end

    assign number_out   = number_q;
    assign overflow     = overflow_q;
    assign number_valid = nvalid_q;

    reg_array #(
        .DEPTH_W (MEM_AW),
        .WIDTH   (DATA_W)
    ) u_mem (
        .clk      (clk),
        .rst_n    (reset),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .re_i     (bus.read_en),
        .raddr_i  (bus.read_add),
        .rdata_o  (bus.data_out),
        .rvalid_o (bus.data_out_valid)
    );

    pipe_delay #(
        .DELAY (TMUX)
    ) u_done (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (start),
        .q_o   (done)
    );
endmodule
`default_nettype wire
